// File: rtl/fam_arbiter_pkg.sv
// Shared float-unit definitions for the FAM issue arbiter: request payload
// layout, default sizing constants and a tag-width helper.
package fam_arbiter_pkg;

    // Default number of FAM operations allowed in flight.
    localparam int fam_els_default_lp = 4;

    // Default FAM result width.
    localparam int fam_data_width_lp = 32;

    // Request payload carried from an FPI pipeline to the FAM.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] frs1;
        logic [31:0] frs2;
    } fam_req_payload_t;

    localparam int fam_payload_width_lp = $bits(fam_req_payload_t);

    // Width of a requester index. A single requester still needs one bit.
    function automatic int fam_tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fam_arbiter_tag_fifo.sv
// In-order FIFO of requester tags. Each FAM issue pushes the owning
// requester index; each consumed FAM result pops it. Occupancy is exported
// as the in-flight count.
module fam_arb_tag_fifo
    import fam_arbiter_pkg::*;
#(
    parameter int els_p   = fam_els_default_lp,
    parameter int width_p = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       pop_i,
    output logic [width_p-1:0]         data_o,
    output logic [$clog2(els_p+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                do_push;
    logic                do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths stay legal.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign full_o  = (count_q == cnt_w_lp'(els_p));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Next-state for pointers and occupancy; push+pop together keeps the count.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers and count, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Tag storage: contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // The arbiter never pushes when full nor pops when empty.
    assert property (@(posedge clk) disable iff (reset) !(push_i && full_o));
    assert property (@(posedge clk) disable iff (reset) !(pop_i && empty_o));

endmodule

// File: rtl/fam_arbiter.sv
// Round-robin arbiter sharing one FAM between several FPI pipelines.
// Grants are combinational and limited by FAM readiness and the number of
// operations in flight. Results come back in issue order and are steered
// to their owner using a tag FIFO.
module fam_arbiter
    import fam_arbiter_pkg::*;
#(
    parameter int num_req_p       = 2,
    parameter int payload_width_p = fam_payload_width_lp,
    parameter int data_width_p    = fam_data_width_lp,
    parameter int els_p           = fam_els_default_lp
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [num_req_p-1:0]                      req_v_i,
    input  logic [num_req_p-1:0][payload_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                      req_ready_o,
    output logic                                      fam_v_o,
    output logic [payload_width_p-1:0]                fam_data_o,
    input  logic                                      fam_ready_i,
    input  logic                                      fam_v_i,
    input  logic [data_width_p-1:0]                   fam_data_i,
    output logic                                      fam_yumi_o,
    output logic [num_req_p-1:0]                      resp_v_o,
    output logic [data_width_p-1:0]                   resp_data_o,
    input  logic [num_req_p-1:0]                      resp_yumi_i,
    output logic [$clog2(els_p+1)-1:0]                inflight_o
);

    localparam int tag_w_lp = fam_tag_width(num_req_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [tag_w_lp-1:0]  last_grant_q, last_grant_d;
    logic [tag_w_lp-1:0]  grant_idx;
    logic [tag_w_lp-1:0]  cand;
    logic                 grant_found;
    logic [num_req_p-1:0] grant_oh;
    logic                 eligible;
    logic [tag_w_lp-1:0]  head_tag;
    logic [cnt_w_lp-1:0]  fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [num_req_p-1:0] resp_v;
    logic                 yumi;

    // Full is taken from the registered count, so a same-cycle pop cannot
    // open a slot for a new grant.
    assign eligible = ~reset & fam_ready_i & ~fifo_full;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = last_grant_q;
        grant_found = 1'b0;
        cand        = '0;
        if (eligible) begin
            for (int i = 1; i <= num_req_p; i++) begin
                cand = tag_w_lp'((int'(last_grant_q) + i) % num_req_p);
                if (!grant_found && req_v_i[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign last_grant_d = grant_found ? grant_idx : last_grant_q;

    // Priority pointer moves only on a real grant; after reset requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= tag_w_lp'(num_req_p - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign req_ready_o = grant_oh;
    assign fam_v_o     = grant_found;
    assign fam_data_o  = grant_found ? req_data_i[grant_idx] : '0;

    // Owner tags of issued operations, oldest at the head.
    fam_arb_tag_fifo #(
        .els_p   (els_p),
        .width_p (tag_w_lp)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (grant_found),
        .data_i  (grant_idx),
        .pop_i   (yumi),
        .data_o  (head_tag),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Steer the head FAM result to its owner; only the owner's yumi consumes it.
    always_comb begin
        resp_v = '0;
        if (!reset && fam_v_i && !fifo_empty) begin
            resp_v[head_tag] = 1'b1;
        end
        yumi = resp_v[head_tag] & resp_yumi_i[head_tag];
    end

    assign resp_v_o    = resp_v;
    assign fam_yumi_o  = yumi;
    assign resp_data_o = reset ? '0 : fam_data_i;
    assign inflight_o  = reset ? '0 : fifo_count;

    // A FAM result with nothing in flight means the FAM and the tag FIFO disagree.
    assert property (@(posedge clk) disable iff (reset) !(fam_v_i && fifo_empty));
    assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready_o));

endmodule

// File: tb/tb_fam_arbiter.sv
// Bench for fam_arbiter: table of per-cycle vectors with expected outputs,
// an owner-tag scoreboard for returned results, and hand-written reset sequences.
module tb_fam_arbiter;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_v_i;
    logic [1:0][95:0]  req_data_i;
    logic [1:0]        req_ready_o;
    logic              fam_v_o;
    logic [95:0]       fam_data_o;
    logic              fam_ready_i;
    logic              fam_v_i;
    logic [31:0]       fam_data_i;
    logic              fam_yumi_o;
    logic [1:0]        resp_v_o;
    logic [31:0]       resp_data_o;
    logic [1:0]        resp_yumi_i;
    logic [2:0]        inflight_o;

    always #5 clk = ~clk;

    fam_arbiter #(
        .num_req_p       (2),
        .payload_width_p (96),
        .data_width_p    (32),
        .els_p           (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_v_i     (req_v_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .fam_v_o     (fam_v_o),
        .fam_data_o  (fam_data_o),
        .fam_ready_i (fam_ready_i),
        .fam_v_i     (fam_v_i),
        .fam_data_i  (fam_data_i),
        .fam_yumi_o  (fam_yumi_o),
        .resp_v_o    (resp_v_o),
        .resp_data_o (resp_data_o),
        .resp_yumi_i (resp_yumi_i),
        .inflight_o  (inflight_o)
    );

    typedef struct {
        logic [1:0]  req_v;
        logic        rdy;
        logic        fv;
        logic [31:0] fdata;
        logic [1:0]  yumi;
        logic [1:0]  e_ready;
        logic [1:0]  e_resp;
        logic        e_yumi;
        logic [2:0]  e_infl;
    } vec_t;

    vec_t vecs[$];
    int   sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] rq, input logic rd, input logic fv,
                       input logic [31:0] fd, input logic [1:0] ym,
                       input logic [1:0] er, input logic [1:0] ers,
                       input logic ey, input logic [2:0] ei);
        vec_t v;
        v = '{rq, rd, fv, fd, ym, er, ers, ey, ei};
        vecs.push_back(v);
    endtask

    task automatic drive_payload(input int n);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] w0, w1, w2;
            w0 = 32'hC0DE0000 + 32'(n);
            w1 = 32'(i);
            w2 = 32'hF00D0000 + 32'(i);
            req_data_i[i] = {w0, w1, w2};
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        logic [95:0] exp_pl;
        req_v_i     = v.req_v;
        fam_ready_i = v.rdy;
        fam_v_i     = v.fv;
        fam_data_i  = v.fdata;
        resp_yumi_i = v.yumi;
        drive_payload(n);
        #2;
        exp_pl = '0;
        for (int i = 0; i < 2; i++) begin
            if (v.e_ready[i]) exp_pl = req_data_i[i];
        end
        chk($sformatf("ready[%0d]", n), req_ready_o, v.e_ready);
        chk($sformatf("fam_v[%0d]", n), fam_v_o, |v.e_ready);
        chk($sformatf("fam_data[%0d]", n), fam_data_o, exp_pl);
        chk($sformatf("resp_v[%0d]", n), resp_v_o, v.e_resp);
        chk($sformatf("yumi[%0d]", n), fam_yumi_o, v.e_yumi);
        chk($sformatf("inflight[%0d]", n), inflight_o, v.e_infl);
        chk($sformatf("resp_data[%0d]", n), resp_data_o, v.fdata);
        // Scoreboard: owner of the oldest outstanding issue.
        chk($sformatf("sb_count[%0d]", n), inflight_o, sb.size());
        if (resp_v_o != 2'b00) begin
            if (sb.size() == 0) begin
                chk($sformatf("sb_unexpected_resp[%0d]", n), resp_v_o, 2'b00);
            end else begin
                chk($sformatf("sb_owner[%0d]", n), resp_v_o, 2'b01 << sb[0]);
            end
        end
        if (v.e_yumi && sb.size() > 0) void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            if (v.e_ready[i]) sb.push_back(i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready_o, 2'b00);
        chk({tag, "_fam_v"}, fam_v_o, 1'b0);
        chk({tag, "_fam_data"}, fam_data_o, 96'h0);
        chk({tag, "_resp_v"}, resp_v_o, 2'b00);
        chk({tag, "_yumi"}, fam_yumi_o, 1'b0);
        chk({tag, "_inflight"}, inflight_o, 3'd0);
    endtask

    initial begin
        // Sequence A: both request every cycle, results consumed at once.
        add(2'b11, 1, 0, 32'h0,  2'b11, 2'b01, 2'b00, 0, 3'd0);
        add(2'b11, 1, 1, 32'hA1, 2'b11, 2'b10, 2'b01, 1, 3'd1);
        add(2'b11, 1, 1, 32'hA2, 2'b11, 2'b01, 2'b10, 1, 3'd1);
        add(2'b11, 1, 1, 32'hA3, 2'b11, 2'b10, 2'b01, 1, 3'd1);
        add(2'b00, 1, 1, 32'hA4, 2'b11, 2'b00, 2'b10, 1, 3'd1);
        add(2'b00, 1, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 3'd0);
        // Sequence B: issue order 1,0,1; FAM not ready; wrong-owner yumi; returns A,B,C.
        add(2'b10, 1, 0, 32'h0,  2'b00, 2'b10, 2'b00, 0, 3'd0);
        add(2'b01, 1, 0, 32'h0,  2'b00, 2'b01, 2'b00, 0, 3'd1);
        add(2'b10, 1, 0, 32'h0,  2'b00, 2'b10, 2'b00, 0, 3'd2);
        add(2'b11, 0, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 3'd3);
        add(2'b00, 1, 1, 32'hA,  2'b01, 2'b00, 2'b10, 0, 3'd3);
        add(2'b00, 1, 1, 32'hA,  2'b11, 2'b00, 2'b10, 1, 3'd3);
        add(2'b00, 1, 1, 32'hB,  2'b11, 2'b00, 2'b01, 1, 3'd2);
        add(2'b00, 1, 1, 32'hC,  2'b11, 2'b00, 2'b10, 1, 3'd1);
        // Sequence C: fill to els_p, full blocks grant even with a pop.
        add(2'b01, 1, 0, 32'h0,  2'b00, 2'b01, 2'b00, 0, 3'd0);
        add(2'b01, 1, 0, 32'h0,  2'b00, 2'b01, 2'b00, 0, 3'd1);
        add(2'b01, 1, 0, 32'h0,  2'b00, 2'b01, 2'b00, 0, 3'd2);
        add(2'b01, 1, 0, 32'h0,  2'b00, 2'b01, 2'b00, 0, 3'd3);
        add(2'b01, 1, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 3'd4);
        add(2'b01, 1, 1, 32'h11, 2'b01, 2'b00, 2'b01, 1, 3'd4);
        add(2'b01, 1, 0, 32'h0,  2'b00, 2'b01, 2'b00, 0, 3'd3);
        // Sequence D: drain to 2, then push+pop every cycle for 10 cycles.
        add(2'b00, 1, 1, 32'h21, 2'b01, 2'b00, 2'b01, 1, 3'd4);
        add(2'b00, 1, 1, 32'h22, 2'b01, 2'b00, 2'b01, 1, 3'd3);
        for (int k = 0; k < 10; k++) begin
            add(2'b11, 1, 1, 32'h100 + 32'(k), 2'b11,
                (k % 2 == 0) ? 2'b10 : 2'b01,
                (k >= 2 && k % 2 == 0) ? 2'b10 : 2'b01,
                1, 3'd2);
        end
        // Sequence E: one more issue to reach three in flight.
        add(2'b10, 1, 0, 32'h0,  2'b00, 2'b10, 2'b00, 0, 3'd2);

        // Power-on reset with requests asserted: outputs stay quiet.
        reset       = 1'b1;
        req_v_i     = 2'b11;
        fam_ready_i = 1'b1;
        fam_v_i     = 1'b0;
        fam_data_i  = 32'h0;
        resp_yumi_i = 2'b00;
        drive_payload(0);
        #2;
        chk_all_zero("por0");
        @(posedge clk);
        #1;
        chk_all_zero("por1");
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n], n);
        end

        // Mid-operation reset with three operations in flight.
        req_v_i     = 2'b00;
        fam_v_i     = 1'b0;
        resp_yumi_i = 2'b00;
        #2;
        chk("pre_rst_inflight", inflight_o, 3'd3);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        req_v_i     = 2'b11;
        fam_v_i     = 1'b1;
        fam_data_i  = 32'hDEAD;
        resp_yumi_i = 2'b11;
        #2;
        chk_all_zero("midrst");
        chk("midrst_resp_data", resp_data_o, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        req_v_i     = 2'b11;
        fam_v_i     = 1'b0;
        fam_data_i  = 32'h0;
        resp_yumi_i = 2'b00;
        #2;
        chk("post_rst_inflight", inflight_o, 3'd0);
        chk("post_rst_resp_v", resp_v_o, 2'b00);
        chk("post_rst_grant", req_ready_o, 2'b01);
        @(posedge clk);
        #1;
        req_v_i = 2'b11;
        #2;
        chk("post_rst_grant2", req_ready_o, 2'b10);
        chk("post_rst_inflight2", inflight_o, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
